// File: rtl/sdm_chan_ctrl_if.sv
// Request channel for the SDM channel-switch sequencer.
// The master presents {integer N, 16-bit fraction} with valid.
// The slave accepts the request on the cycle where both valid and ready are high.
interface sdm_chan_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_n;
  logic [15:0] req_frac;

  modport master (
    output req_valid,
    output req_n,
    output req_frac,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_n,
    input  req_frac,
    output req_ready
  );
endinterface

// File: rtl/sdm_chan_ctrl.sv
// sdm_chan_ctrl: channel-switch sequencer for the SDM fractional-N loop divider.
// Sequence per accepted request: freeze noise-cancel, load the frequency word,
// wait for lock (or time out), then restore noise-cancel.
// Optional build macro FREQ_RAMP_EN: the word ramps toward the target in
// RAMP_STEP increments instead of jumping in one cycle.
// All outputs are registers, so an asserted reset forces them immediately.
module sdm_chan_ctrl #(
  parameter logic [5:0]  N_MIN      = 6'd8,
  parameter logic [5:0]  N_MAX      = 6'd55,
  parameter logic [5:0]  N_RST      = 6'd30,
  parameter int unsigned FREEZE_CYC = 4,
  parameter int unsigned LOCK_HOLD  = 16,
  parameter int unsigned TIMEOUT    = 4096
`ifdef FREQ_RAMP_EN
  ,
  parameter logic [21:0] RAMP_STEP  = 22'h000400
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sdm_chan_ctrl_if.slave        req_if,
  input  logic                  i_nc_cfg_en,
  input  logic                  i_lock_det,
  output logic [5:0]            o_n,
  output logic [15:0]           o_sdm_in,
  output logic                  o_sdm_nc_enable,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_lock_err,
  output logic                  o_range_err
);

  localparam logic [7:0]  FRZ_LAST  = 8'(FREEZE_CYC - 1);
  localparam logic [8:0]  HOLD_END  = 9'(LOCK_HOLD);
  localparam logic [16:0] TO_END    = 17'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FREEZE = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  logic [21:0] r_word;
  logic [21:0] r_target;
  logic [7:0]  r_frz_cnt;
  logic [7:0]  r_hold_cnt;
  logic [15:0] r_to_cnt;
  logic        r_nc_en;
  logic        r_busy;
  logic        r_ready;
  logic        r_done;
  logic        r_lock_err;
  logic        r_range_err;

  state_t      w_state_nx;
  logic [21:0] w_word_nx;
  logic [21:0] w_target_nx;
  logic [7:0]  w_frz_nx;
  logic [7:0]  w_hold_nx;
  logic [15:0] w_to_nx;
  logic        w_nc_nx;
  logic        w_done_nx;
  logic        w_lock_err_nx;
  logic        w_range_err_nx;

  logic        w_handshake;
  logic        w_in_range;
  logic [8:0]  w_hold_inc;
  logic [16:0] w_to_inc;

  assign w_handshake = req_if.req_valid & r_ready;
  assign w_in_range  = (req_if.req_n >= N_MIN) && (req_if.req_n <= N_MAX);
  assign w_hold_inc  = {1'b0, r_hold_cnt} + 9'd1;
  assign w_to_inc    = {1'b0, r_to_cnt} + 17'd1;

`ifdef FREQ_RAMP_EN
  // Ramp direction and remaining distance; the word moves monotonically
  // between two legal words, so N never leaves N_MIN..N_MAX.
  logic        w_up;
  logic [21:0] w_dist;
  assign w_up   = (r_target >= r_word);
  assign w_dist = w_up ? (r_target - r_word) : (r_word - r_target);
`endif

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    w_state_nx     = r_state;
    w_word_nx      = r_word;
    w_target_nx    = r_target;
    w_frz_nx       = r_frz_cnt;
    w_hold_nx      = r_hold_cnt;
    w_to_nx        = r_to_cnt;
    w_nc_nx        = r_nc_en;
    w_done_nx      = 1'b0;
    w_lock_err_nx  = 1'b0;
    w_range_err_nx = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_nc_nx = i_nc_cfg_en;
        if (w_handshake) begin
          if (w_in_range) begin
            w_target_nx = {req_if.req_n, req_if.req_frac};
            w_frz_nx    = 8'd0;
            w_nc_nx     = 1'b0;
            w_state_nx  = S_FREEZE;
          end else begin
            // Rejected request: pulse the error and leave the word alone.
            w_range_err_nx = 1'b1;
          end
        end else begin
          w_state_nx = S_IDLE;
        end
      end

      S_FREEZE: begin
        w_nc_nx = 1'b0;
        if (r_frz_cnt == FRZ_LAST) begin
          w_state_nx = S_LOAD;
        end else begin
          w_frz_nx = r_frz_cnt + 8'd1;
        end
      end

      S_LOAD: begin
        w_nc_nx = 1'b0;
`ifdef FREQ_RAMP_EN
        if (w_dist <= RAMP_STEP) begin
          w_word_nx  = r_target;
          w_hold_nx  = 8'd0;
          w_to_nx    = 16'd0;
          w_state_nx = S_SETTLE;
        end else if (w_up) begin
          w_word_nx = r_word + RAMP_STEP;
        end else begin
          w_word_nx = r_word - RAMP_STEP;
        end
`else
        w_word_nx  = r_target;
        w_hold_nx  = 8'd0;
        w_to_nx    = 16'd0;
        w_state_nx = S_SETTLE;
`endif
      end

      S_SETTLE: begin
        w_nc_nx   = 1'b0;
        w_hold_nx = i_lock_det ? w_hold_inc[7:0] : 8'd0;
        w_to_nx   = w_to_inc[15:0];
        // Lock is tested first so it wins over a simultaneous timeout.
        if (i_lock_det && (w_hold_inc == HOLD_END)) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_DONE;
        end else if (w_to_inc == TO_END) begin
          w_done_nx     = 1'b1;
          w_lock_err_nx = 1'b1;
          w_state_nx    = S_DONE;
        end else begin
          w_state_nx = S_SETTLE;
        end
      end

      S_DONE: begin
        w_nc_nx    = i_nc_cfg_en;
        w_state_nx = S_IDLE;
      end

      default: begin
        w_nc_nx    = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset restores divider-reset word and IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_word      <= {N_RST, 16'h0000};
      r_target    <= {N_RST, 16'h0000};
      r_frz_cnt   <= 8'd0;
      r_hold_cnt  <= 8'd0;
      r_to_cnt    <= 16'd0;
      r_nc_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_lock_err  <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_word      <= w_word_nx;
      r_target    <= w_target_nx;
      r_frz_cnt   <= w_frz_nx;
      r_hold_cnt  <= w_hold_nx;
      r_to_cnt    <= w_to_nx;
      r_nc_en     <= w_nc_nx;
      r_busy      <= (w_state_nx != S_IDLE);
      r_ready     <= (w_state_nx == S_IDLE);
      r_done      <= w_done_nx;
      r_lock_err  <= w_lock_err_nx;
      r_range_err <= w_range_err_nx;
    end
  end

  assign req_if.req_ready = r_ready;
  assign o_n              = r_word[21:16];
  assign o_sdm_in         = r_word[15:0];
  assign o_sdm_nc_enable  = r_nc_en;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_lock_err       = r_lock_err;
  assign o_range_err      = r_range_err;

endmodule

// File: tb/tb_sdm_chan_ctrl.sv
// Self-checking bench for sdm_chan_ctrl. Expected values come from a
// timeline model: freeze length, load length (jump or ramp), and a settle
// length found by scanning the lock_det pattern for a run of LOCK_HOLD highs.
module tb_sdm_chan_ctrl;
  localparam int N_MIN      = 8;
  localparam int N_MAX      = 55;
  localparam int N_RST      = 30;
  localparam int FREEZE_CYC = 4;
  localparam int LOCK_HOLD  = 16;
  localparam int TIMEOUT    = 4096;
  localparam int RAMP_STEP  = 'h400;

  logic        clk = 1'b0;
  logic        rst;
  logic        nc_cfg_en;
  logic        lock_det;
  logic [5:0]  n_o;
  logic [15:0] sdm_o;
  logic        nc_o, busy_o, done_o, lock_err_o, range_err_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned m_word;
  bit          pat [1:TIMEOUT];

  sdm_chan_ctrl_if req_if ();

  sdm_chan_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .req_if          (req_if),
    .i_nc_cfg_en     (nc_cfg_en),
    .i_lock_det      (lock_det),
    .o_n             (n_o),
    .o_sdm_in        (sdm_o),
    .o_sdm_nc_enable (nc_o),
    .o_busy          (busy_o),
    .o_done          (done_o),
    .o_lock_err      (lock_err_o),
    .o_range_err     (range_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word after k load steps starting from w0 toward t.
  function automatic int unsigned exp_word(input int unsigned w0, input int unsigned t, input int k);
    if (k <= 0) return w0;
`ifdef FREQ_RAMP_EN
    if (t >= w0) return (w0 + k * RAMP_STEP >= t) ? t : w0 + k * RAMP_STEP;
    else         return (w0 <= t + k * RAMP_STEP) ? t : w0 - k * RAMP_STEP;
`else
    return t;
`endif
  endfunction

  // Number of cycles spent in LOAD.
  function automatic int load_cycles(input int unsigned w0, input int unsigned t);
`ifdef FREQ_RAMP_EN
    int unsigned dist;
    dist = (t >= w0) ? t - w0 : w0 - t;
    return (dist == 0) ? 1 : int'((dist + RAMP_STEP - 1) / RAMP_STEP);
`else
    return 1;
`endif
  endfunction

  // Settle length: first cycle where the run of highs reaches LOCK_HOLD, else TIMEOUT with error.
  function automatic void settle_model(output int d, output bit err);
    int run;
    run = 0;
    d   = TIMEOUT;
    err = 1'b1;
    for (int j = 1; j <= TIMEOUT; j++) begin
      run = pat[j] ? run + 1 : 0;
      if (run == LOCK_HOLD) begin
        d   = j;
        err = 1'b0;
        return;
      end
    end
  endfunction

  task automatic fill_pat(input int mode);
    for (int j = 1; j <= TIMEOUT; j++)
      pat[j] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 19) != 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_n"},      {26'd0, n_o}, N_RST);
    chk({tag, "_sdm"},    {16'd0, sdm_o}, 32'd0);
    chk({tag, "_nc"},     {31'd0, nc_o}, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy_o}, 32'd0);
    chk({tag, "_done"},   {31'd0, done_o}, 32'd0);
    chk({tag, "_lerr"},   {31'd0, lock_err_o}, 32'd0);
    chk({tag, "_rerr"},   {31'd0, range_err_o}, 32'd0);
  endtask

  // Runs one accepted request from the current negedge; abort_c >= 0 asserts reset at that point.
  task automatic run_seq(input logic [5:0] n, input logic [15:0] f, input bit cfg,
                         input int abort_c, input string tag);
    int unsigned t, w0;
    int          ld, d, e_end, j;
    bit          err;
    t  = {10'd0, n, f};
    w0 = m_word;
    ld = load_cycles(w0, t);
    settle_model(d, err);
    e_end = FREEZE_CYC + ld + d;
    nc_cfg_en        = cfg;
    req_if.req_valid = 1'b1;
    req_if.req_n     = n;
    req_if.req_frac  = f;
    for (int c = 0; c <= e_end + 1; c++) begin
      @(negedge clk);
      if (c == abort_c) begin
        rst = 1'b1;
        #1;
        chk_reset_vals({tag, "_abort"});
        chk({tag, "_abort_rdy"}, {31'd0, req_if.req_ready}, 32'd1);
        req_if.req_valid = 1'b0;
        m_word = N_RST << 16;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (c <= e_end) begin
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        chk({tag, "_rdy"},  {31'd0, req_if.req_ready}, 32'd0);
        chk({tag, "_nc"},   {31'd0, nc_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, {31'd0, c == e_end});
        chk({tag, "_lerr"}, {31'd0, lock_err_o}, {31'd0, (c == e_end) && err});
        chk({tag, "_word"}, {10'd0, n_o, sdm_o}, exp_word(w0, t, c - FREEZE_CYC));
      end else begin
        chk({tag, "_busy_end"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_rdy_end"},  {31'd0, req_if.req_ready}, 32'd1);
        chk({tag, "_done_end"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_nc_end"},   {31'd0, nc_o}, {31'd0, cfg});
        chk({tag, "_word_end"}, {10'd0, n_o, sdm_o}, t);
      end
      j = c + 1 - (FREEZE_CYC + ld);
      lock_det = (j >= 1 && j <= TIMEOUT) ? pat[j] : 1'($urandom_range(0, 1));
      // Requests offered while busy must be ignored.
      req_if.req_valid = (c <= e_end) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_if.req_n     = 6'($urandom);
      req_if.req_frac  = 16'($urandom);
    end
    m_word = t;
  endtask

  task automatic run_reject(input logic [5:0] n, input string tag);
    req_if.req_valid = 1'b1;
    req_if.req_n     = n;
    req_if.req_frac  = 16'($urandom);
    @(negedge clk);
    chk({tag, "_rerr"}, {31'd0, range_err_o}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_word"}, {10'd0, n_o, sdm_o}, m_word);
    req_if.req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rerr_off"}, {31'd0, range_err_o}, 32'd0);
    chk({tag, "_word2"}, {10'd0, n_o, sdm_o}, m_word);
    chk({tag, "_busy2"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    nc_cfg_en        = 1'b0;
    lock_det         = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_n     = 6'd0;
    req_if.req_frac  = 16'd0;
    m_word           = N_RST << 16;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    // Idle: noise-cancel follows configuration with one cycle latency.
    nc_cfg_en = 1'b1;
    @(negedge clk);
    chk("idle_nc1", {31'd0, nc_o}, 32'd1);
    chk("idle_rdy", {31'd0, req_if.req_ready}, 32'd1);
    chk("idle_word", {10'd0, n_o, sdm_o}, m_word);
    nc_cfg_en = 1'b0;
    @(negedge clk);
    chk("idle_nc0", {31'd0, nc_o}, 32'd0);

    // Basic channel switch with lock held.
    fill_pat(0);
    run_seq(6'd40, 16'h8000, 1'b1, -1, "sw40");

    // Out-of-range requests.
    run_reject(6'd7, "rej7");
    run_reject(6'd56, "rej56");

    // Lock never seen: timeout.
    fill_pat(1);
    run_seq(6'd45, 16'h1234, 1'b0, -1, "tmo");

    // Dropout on hold cycle 10 restarts the count.
    fill_pat(0);
    pat[10] = 1'b0;
    run_seq(6'd20, 16'h0F0F, 1'b1, -1, "drop10");

    // Lock completes on the same cycle the timeout expires: lock wins.
    fill_pat(1);
    for (int j = TIMEOUT - LOCK_HOLD + 1; j <= TIMEOUT; j++) pat[j] = 1'b1;
    run_seq(6'd33, 16'h0001, 1'b1, -1, "tie");

    // Reset during SETTLE, then a fresh request.
    fill_pat(0);
    run_seq(6'd50, 16'hAAAA, 1'b1, FREEZE_CYC + load_cycles(m_word, {10'd0, 6'd50, 16'hAAAA}) + 5, "abort");
    run_seq(6'd25, 16'h5555, 1'b1, -1, "after");

    // Same word as current, legal endpoints, and the 30.0 <-> 31.0 ramp case.
    run_seq(6'd25, 16'h5555, 1'b0, -1, "same");
    run_seq(6'd8, 16'h0000, 1'b1, -1, "nmin");
    run_seq(6'd55, 16'hFFFF, 1'b1, -1, "nmax");
    run_seq(6'd30, 16'h0000, 1'b1, -1, "to30");
    run_seq(6'd31, 16'h0000, 1'b1, -1, "up31");
    run_seq(6'd30, 16'h0000, 1'b1, -1, "dn30");

    // Randomized requests with sporadic lock dropouts.
    for (int i = 0; i < 16; i++) begin
      logic [5:0] rn;
      rn = 6'($urandom);
      if (rn >= N_MIN && rn <= N_MAX) begin
        fill_pat(2);
        run_seq(rn, 16'($urandom), 1'($urandom_range(0, 1)), -1, "rnd");
      end else begin
        run_reject(rn, "rnd_rej");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
